hazard_scoreboard: RTL and testbench

- Producer of the `hazard_detected` signal consumed by the ID-stage control decoder.
- Tracks register writes in flight in EXE, MEM and WB with an internal shadow pipeline of destination tags.
- Compares the ID-stage source registers against those tags and asserts a stall when an operand is not yet available.
- Supports a forwarding-enabled mode (load-use stall only) and a no-forwarding mode (stall on any RAW). Keeps a saturating stall counter for performance monitoring.

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to hazard scoreboard bundle.
// master: ID-side driver, slave: scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_LEN  = 5,
  parameter int STALL_CNT_LEN = 16
);
  logic                     id_valid;
  logic [REG_ADDR_LEN-1:0]  src1;
  logic [REG_ADDR_LEN-1:0]  src2;
  logic                     two_src;
  logic [REG_ADDR_LEN-1:0]  id_dest;
  logic                     id_wb_en;
  logic                     id_mem_r_en;
  logic                     forward_en;
  logic                     flush;
  logic                     freeze;
  logic                     hazard_detected;
  logic [STALL_CNT_LEN-1:0] stall_count;

  modport master (
    output id_valid, src1, src2, two_src,
    output id_dest, id_wb_en, id_mem_r_en,
    output forward_en, flush, freeze,
    input  hazard_detected, stall_count
  );

  modport slave (
    input  id_valid, src1, src2, two_src,
    input  id_dest, id_wb_en, id_mem_r_en,
    input  forward_en, flush, freeze,
    output hazard_detected, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: shadow EXE/MEM/WB dest tags vs ID sources.
// Ports: clk, rst (sync, active-high), sb (slave: ID bundle, stall out).
module hazard_scoreboard #(
  parameter int REG_ADDR_LEN  = 5,
  parameter int STALL_CNT_LEN = 16,
  parameter int WB_HAZARD     = 0
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);

  typedef logic [REG_ADDR_LEN-1:0] reg_t;

  typedef struct packed {
    logic wb;
    logic mem_r;
    reg_t dest;
  } ent_t;

  localparam logic WB_CHK = (WB_HAZARD != 0);

  ent_t exe_q, exe_d;
  ent_t mem_q, mem_d;
  ent_t wb_q,  wb_d;

  logic [STALL_CNT_LEN-1:0] cnt_q, cnt_d;

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;
  logic hazard;

  function automatic logic hit(
    input ent_t e,
    input reg_t s
  );
    return e.wb && (s != '0) && (e.dest == s);
  endfunction

  function automatic logic any_hit(
    input ent_t e,
    input reg_t s1,
    input reg_t s2,
    input logic two
  );
    return hit(e, s1) || (two && hit(e, s2));
  endfunction

  // Only source fields and stored tags feed the stall; the ID
  // dest/wb/load fields stay off this path so the decoder can
  // gate them on hazard without a loop.
  always_comb begin
    exe_hit = any_hit(exe_q, sb.src1, sb.src2, sb.two_src);
    mem_hit = any_hit(mem_q, sb.src1, sb.src2, sb.two_src);
    wb_hit  = any_hit(wb_q,  sb.src1, sb.src2, sb.two_src);
    hazard  = 1'b0;
    if (sb.id_valid) begin
      if (sb.forward_en) begin
        hazard = exe_hit && exe_q.mem_r;
      end else begin
        hazard = exe_hit || mem_hit || (WB_CHK && wb_hit);
      end
    end
  end

  assign sb.hazard_detected = hazard;
  assign sb.stall_count     = cnt_q;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!sb.freeze) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      exe_d = '0;
      if (sb.id_valid && !hazard && !sb.flush) begin
        exe_d.wb    = sb.id_wb_en;
        exe_d.mem_r = sb.id_mem_r_en;
        exe_d.dest  = sb.id_dest;
      end
      if (hazard && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Reference: per-register youngest-writer age model.
module tb_hazard_scoreboard;

  localparam int RA  = 5;
  localparam int SCL = 10;
  localparam int WBH = 0;
  localparam int CMAX = (1 << SCL) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .REG_ADDR_LEN (RA),
    .STALL_CNT_LEN(SCL)
  ) sb ();

  hazard_scoreboard #(
    .REG_ADDR_LEN (RA),
    .STALL_CNT_LEN(SCL),
    .WB_HAZARD    (WBH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: pipeline advance count and, per register, the advance
  // index at which its youngest writer entered EXE
  bit vld[32];
  int wadv[32];
  bit wld[32];
  int adv = 0;
  int cnt_m = 0;
  bit last_haz;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int s);
    int age;
    if (s == 0 || !vld[s]) return 1'b0;
    age = adv - wadv[s];
    if (sb.forward_en) return (age == 0) && wld[s];
    return age <= ((WBH != 0) ? 2 : 1);
  endfunction

  function automatic bit model_haz();
    bit h;
    h = hit(int'(sb.src1));
    if (sb.two_src) h = h || hit(int'(sb.src2));
    return sb.id_valid && h;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) vld[r] = 1'b0;
    cnt_m = 0;
  endtask

  task automatic model_edge(input bit h);
    if (rst) begin
      model_clear();
    end else if (!sb.freeze) begin
      if (h && cnt_m < CMAX) cnt_m++;
      adv++;
      if (sb.id_valid && !h && !sb.flush && sb.id_wb_en) begin
        vld[sb.id_dest]  = 1'b1;
        wadv[sb.id_dest] = adv;
        wld[sb.id_dest]  = sb.id_mem_r_en;
      end
    end
  endtask

  // called just after a falling edge with inputs already driven
  task automatic tick();
    bit h;
    #1;
    h = model_haz();
    last_haz = sb.hazard_detected;
    chk("haz", int'(sb.hazard_detected), int'(h));
    chk("cnt", int'(sb.stall_count), cnt_m);
    @(posedge clk);
    model_edge(h);
    @(negedge clk);
  endtask

  task automatic set_id(
    input bit v, input int s1, input int s2, input bit two,
    input int d, input bit wb, input bit ld
  );
    sb.id_valid    = v;
    sb.src1        = RA'(s1);
    sb.src2        = RA'(s2);
    sb.two_src     = two;
    sb.id_dest     = RA'(d);
    sb.id_wb_en    = wb;
    sb.id_mem_r_en = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // hold the current ID instruction until it issues
  task automatic run_issue(input string tag, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!last_haz) break;
      n++;
    end
    chk(tag, n, exp);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sb.forward_en = 1'b0;
    sb.flush      = 1'b0;
    sb.freeze     = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) tick();
    chk("idle_cnt", int'(sb.stall_count), 0);

    // load-use with forwarding: one stall
    sb.forward_en = 1'b1;
    set_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 0, 1'b0, 4, 1'b1, 1'b0);
    run_issue("lu_stalls", 1);
    tick();
    chk("lu_cnt", int'(sb.stall_count), 1);

    // no forwarding: ALU result used by src2
    sb.forward_en = 1'b0;
    set_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 1, 5, 1'b1, 6, 1'b1, 1'b0);
    run_issue("raw_two", 2);
    repeat (3) tick();
    set_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 1, 5, 1'b0, 6, 1'b1, 1'b0);
    run_issue("raw_one", 0);
    repeat (3) tick();

    // r0 producer and store producer never stall
    set_id(1'b1, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 0, 0, 1'b1, 9, 1'b1, 1'b0);
    run_issue("r0", 0);
    set_id(1'b1, 0, 0, 1'b0, 8, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 8, 8, 1'b1, 9, 1'b1, 1'b0);
    run_issue("st", 0);
    repeat (3) tick();

    // squashed load does not create a hazard
    set_id(1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b1);
    sb.flush = 1'b1;
    tick();
    sb.flush = 1'b0;
    idle();
    tick();
    set_id(1'b1, 7, 0, 1'b0, 2, 1'b1, 1'b0);
    run_issue("flush", 0);
    repeat (3) tick();

    // freeze during a load-use stall
    sb.forward_en = 1'b1;
    set_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 0, 1'b0, 4, 1'b1, 1'b0);
    sb.freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_haz", int'(last_haz), 1);
    end
    sb.freeze = 1'b0;
    run_issue("frz_lu", 1);
    repeat (3) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sb.id_valid    = ($urandom_range(0, 9) != 0);
      sb.src1        = RA'($urandom_range(0, 7));
      sb.src2        = RA'($urandom_range(0, 7));
      sb.two_src     = ($urandom_range(0, 1) != 0);
      sb.id_dest     = RA'($urandom_range(0, 7));
      sb.id_wb_en    = ($urandom_range(0, 3) != 0);
      sb.id_mem_r_en = ($urandom_range(0, 2) == 0);
      sb.forward_en  = ($urandom_range(0, 1) != 0);
      sb.flush       = ($urandom_range(0, 9) == 0);
      sb.freeze      = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    sb.flush = 1'b0;
    sb.freeze = 1'b0;

    // saturate the counter with a self-dependent chain
    do_reset();
    sb.forward_en = 1'b0;
    set_id(1'b1, 5, 0, 1'b0, 5, 1'b1, 1'b0);
    for (int i = 0; i < 1600; i++) tick();
    chk("sat", int'(sb.stall_count), CMAX);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (sb.hazard_detected) break;
      tick();
    end
    #1;
    chk("pre_rst_haz", int'(sb.hazard_detected), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_haz", int'(sb.hazard_detected), 0);
    chk("rst_cnt", int'(sb.stall_count), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
